// File: rtl/serial_pkg.sv
// Shared definitions for the WIDTH-bit serial word link: state encoding,
// word size, beat count and the chunk-width legality check.
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int WORD_W = 32;

    function automatic int beats_for(input int width);
        return WORD_W / width;
    endfunction

    function automatic bit width_legal(input int width);
        return (width == 1) || (width == 2) || (width == 4) ||
               (width == 8) || (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Link-side and consumer-side signals of the serial receiver; master drives
// chunks and handshakes, slave (the receiver) returns the rebuilt word.
interface serial_receiver_if #(parameter int WIDTH = 4);

    logic [WIDTH-1:0]              din;
    logic                          din_valid;
    logic                          clear;
    logic                          ack;
    logic [serial_pkg::WORD_W-1:0] data_out;
    logic                          data_valid;
    logic                          rx_done;
    logic                          rx_busy;
    logic                          overrun;
    logic                          timeout;

    modport master (
        output din, din_valid, clear, ack,
        input  data_out, data_valid, rx_done, rx_busy, overrun, timeout
    );

    modport slave (
        input  din, din_valid, clear, ack,
        output data_out, data_valid, rx_done, rx_busy, overrun, timeout
    );

endinterface

// File: rtl/serial_gap_timer.sv
// Counts idle cycles between beats of one word; expire fires on the edge
// that completes the TIMEOUT-th consecutive idle cycle.
module serial_gap_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic counting,
    output logic expire
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);

    logic [GAP_W-1:0] gap;

    // Saturates at TIMEOUT so a stuck counting input can never wrap back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if (!counting) begin
            gap <= '0;
        end else if (gap != GAP_W'(TIMEOUT)) begin
            gap <= gap + 1'b1;
        end
    end

    assign expire = counting && (gap >= GAP_W'(TIMEOUT - 1));

endmodule

// File: rtl/serial_receiver.sv
// Rebuilds 32-bit words from WIDTH-bit chunks (MSB chunk first) and holds
// them in a valid/ack register, flagging dropped words and stalled links.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    serial_receiver_if.slave   bus
);

    localparam int BEATS = beats_for(WIDTH);
    localparam int CNT_W = $clog2(BEATS + 1);

    if (!width_legal(WIDTH) || (TIMEOUT < 1)) begin : g_bad_param
        $error("serial_receiver: WIDTH must divide 32 and TIMEOUT must be >= 1");
    end

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   data_out;
    logic                data_valid;
    logic                rx_done;
    logic                overrun;
    logic                timeout;
    logic                accept;
    logic                last;
    logic                load;
    logic                drop;
    logic                counting;
    logic                expire;

    if (WIDTH == WORD_W) begin : g_full_chunk
        assign word = bus.din;
    end else begin : g_shift_chunk
        assign word = {shreg[WORD_W-WIDTH-1:0], bus.din};
    end

    always_comb begin
        accept   = bus.din_valid && !bus.clear;
        last     = accept && (cnt == CNT_W'(BEATS - 1));
        load     = last && (!data_valid || bus.ack);
        drop     = last && data_valid && !bus.ack;
        counting = (state == RECV) && !bus.din_valid && !bus.clear;
    end

    serial_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .counting (counting),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear beats a simultaneous chunk; a completing beat returns to IDLE so
    // the next word's first beat can follow with no bubble.
    always_comb begin
        state_next = state;
        if (bus.clear || expire || last) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = RECV;
        end
    end

    always_comb begin
        bus.rx_busy = (state == RECV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            rx_done    <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            rx_done <= load;
            if (load) begin
                data_valid <= 1'b1;
                data_out   <= word;
            end else if (bus.ack) begin
                data_valid <= 1'b0;
            end
            if (bus.clear) begin
                cnt     <= '0;
                overrun <= 1'b0;
                timeout <= 1'b0;
            end else if (accept) begin
                shreg <= word;
                cnt   <= last ? '0 : cnt + 1'b1;
                if (drop) begin
                    overrun <= 1'b1;
                end
            end else if (expire) begin
                cnt     <= '0;
                timeout <= 1'b1;
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.rx_done    = rx_done;
    assign bus.overrun    = overrun;
    assign bus.timeout    = timeout;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: a vector table for the basic word and
// handshake, then hand-written sequences for overrun, timeout, reset, clear.
module tb_serial_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    serial_receiver_if #(.WIDTH(4))  b4 ();
    serial_receiver_if #(.WIDTH(8))  b8 ();
    serial_receiver_if #(.WIDTH(32)) b32 ();

    serial_receiver #(.WIDTH(4),  .TIMEOUT(16)) dut4  (.clk(clk), .rst(rst), .bus(b4));
    serial_receiver #(.WIDTH(8),  .TIMEOUT(16)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    serial_receiver #(.WIDTH(32), .TIMEOUT(16)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    typedef struct {
        logic [3:0]  din;
        logic        din_valid;
        logic        clear;
        logic        ack;
        logic [31:0] exp_out;
        logic        exp_valid;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic checkAll(input string name, input logic [31:0] dout, input logic dv,
                            input logic done, input logic busy, input logic ovr, input logic tmo);
        checkOutput({name, ".data_out"},   b4.data_out,          dout);
        checkOutput({name, ".data_valid"}, 32'(b4.data_valid),   32'(dv));
        checkOutput({name, ".rx_done"},    32'(b4.rx_done),      32'(done));
        checkOutput({name, ".rx_busy"},    32'(b4.rx_busy),      32'(busy));
        checkOutput({name, ".overrun"},    32'(b4.overrun),      32'(ovr));
        checkOutput({name, ".timeout"},    32'(b4.timeout),      32'(tmo));
    endtask

    task automatic applyStimulus(input logic [3:0] din, input logic dv, input logic clr, input logic ack);
        b4.din       = din;
        b4.din_valid = dv;
        b4.clear     = clr;
        b4.ack       = ack;
    endtask

    task automatic idle4();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendBeats4(input logic [31:0] w, input int n, input bit ackLast);
        for (int k = 0; k < n; k++) begin
            applyStimulus(w[31-4*k -: 4], 1'b1, 1'b0, ackLast && (k == n - 1));
            step();
        end
        idle4();
    endtask

    task automatic ackPulse4();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
        step();
        idle4();
    endtask

    task automatic clearPulse4();
        applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
        step();
        idle4();
    endtask

    initial begin
        logic [31:0] w;
        idle4();
        b8.din = '0;  b8.din_valid = 1'b0;  b8.clear = 1'b0;  b8.ack = 1'b0;
        b32.din = '0; b32.din_valid = 1'b0; b32.clear = 1'b0; b32.ack = 1'b0;

        w = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{din: w[31-4*i -: 4], din_valid: 1'b1, clear: 1'b0, ack: 1'b0,
                        exp_out: (i == 7) ? 32'hDEADBEEF : 32'h0,
                        exp_valid: (i == 7), exp_done: (i == 7), exp_busy: (i != 7)};
        end
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] test 1: DEADBEEF vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].din, vecs[i].din_valid, vecs[i].clear, vecs[i].ack);
            step();
            checkAll($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                     vecs[i].exp_done, vecs[i].exp_busy, 1'b0, 1'b0);
        end
        idle4();

        $display("[TB] test 2: overrun");
        sendBeats4(32'h11111111, 8, 1'b0);
        checkAll("ovr.w1", 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBeats4(32'h22222222, 8, 1'b0);
        checkAll("ovr.w2", 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        clearPulse4();
        checkAll("ovr.clr", 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ackPulse4();
        sendBeats4(32'h11111111, 8, 1'b0);
        sendBeats4(32'h22222222, 8, 1'b1);
        checkAll("ackw2", 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ackPulse4();

        $display("[TB] test 3: timeout");
        sendBeats4(32'hCAF00000, 3, 1'b0);
        repeat (15) step();
        checkAll("tmo.15", 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        checkAll("tmo.16", 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendBeats4(32'hCAFEF00D, 8, 1'b0);
        checkAll("tmo.next", 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        clearPulse4();
        checkAll("tmo.clr", 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] test 4: async reset mid-word");
        sendBeats4(32'h76543210, 5, 1'b0);
        checkAll("rst.pre", 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkAll("rst.async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        sendBeats4(32'h01234567, 8, 1'b0);
        checkAll("rst.after", 32'h01234567, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] test 5: clear vs beat, ack with no data");
        ackPulse4();
        sendBeats4(32'hFFF00000, 3, 1'b0);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
        step();
        idle4();
        checkAll("clr.beat", 32'h01234567, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ackPulse4();
        checkAll("ack.nodata", 32'h01234567, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBeats4(32'h89ABCDEF, 8, 1'b0);
        checkAll("clr.fresh", 32'h89ABCDEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] test 6: other widths");
        w = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            b8.din = w[31-8*k -: 8];
            b8.din_valid = 1'b1;
            step();
            if (k < 3) checkOutput("w8.busy", 32'(b8.rx_busy), 32'd1);
        end
        b8.din_valid = 1'b0;
        checkOutput("w8.data_out",   b8.data_out,          32'h12345678);
        checkOutput("w8.data_valid", 32'(b8.data_valid),   32'd1);
        checkOutput("w8.rx_done",    32'(b8.rx_done),      32'd1);
        b32.din = 32'hA5A5A5A5;
        b32.din_valid = 1'b1;
        step();
        b32.din_valid = 1'b0;
        checkOutput("w32.data_out",   b32.data_out,        32'hA5A5A5A5);
        checkOutput("w32.data_valid", 32'(b32.data_valid), 32'd1);
        checkOutput("w32.rx_done",    32'(b32.rx_done),    32'd1);
        checkOutput("w32.rx_busy",    32'(b32.rx_busy),    32'd0);
        step();
        checkOutput("w32.done_gone",  32'(b32.rx_done),    32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
